// File: rtl/noc_intr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// noc_intr_arbiter_pkg
// Shared constants for the interrupt arbiter: NoC flit geometry, header-flit
// field positions/values (MSG_* / NOC_*), and the arbiter FSM state type.
// Header flit layout (64 bits):
//   [49:42] MSG_DST_X  [41:34] MSG_DST_Y  [33:30] MSG_DST_FBITS
//   [29:22] MSG_LENGTH [21:14] MSG_TYPE   all other bits zero
// -----------------------------------------------------------------------------
package noc_intr_arbiter_pkg;

  localparam int NOC_DATA_WIDTH   = 64;
  localparam int NOC_X_WIDTH      = 8;
  localparam int NOC_Y_WIDTH      = 8;
  localparam int NOC_FBITS_WIDTH  = 4;
  localparam int MSG_LENGTH_WIDTH = 8;
  localparam int MSG_TYPE_WIDTH   = 8;

  localparam int MSG_DST_X_LO     = 42;
  localparam int MSG_DST_Y_LO     = 34;
  localparam int MSG_DST_FBITS_LO = 30;
  localparam int MSG_LENGTH_LO    = 22;
  localparam int MSG_TYPE_LO      = 14;

  localparam logic [NOC_FBITS_WIDTH-1:0]  NOC_FBITS_L1       = 4'b0000;
  localparam logic [MSG_TYPE_WIDTH-1:0]   MSG_TYPE_INTERRUPT = 8'd33;
  localparam logic [MSG_LENGTH_WIDTH-1:0] MSG_LENGTH_ONE     = 8'd1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2
  } arb_state_e;

  // Build a single-body-flit interrupt header for the given destination.
  function automatic logic [NOC_DATA_WIDTH-1:0] make_intr_hdr(
    input logic [NOC_X_WIDTH-1:0] dst_x,
    input logic [NOC_Y_WIDTH-1:0] dst_y
  );
    logic [NOC_DATA_WIDTH-1:0] hdr;
    hdr = '0;
    hdr[MSG_DST_X_LO     +: NOC_X_WIDTH]      = dst_x;
    hdr[MSG_DST_Y_LO     +: NOC_Y_WIDTH]      = dst_y;
    hdr[MSG_DST_FBITS_LO +: NOC_FBITS_WIDTH]  = NOC_FBITS_L1;
    hdr[MSG_LENGTH_LO    +: MSG_LENGTH_WIDTH] = MSG_LENGTH_ONE;
    hdr[MSG_TYPE_LO      +: MSG_TYPE_WIDTH]   = MSG_TYPE_INTERRUPT;
    return hdr;
  endfunction

endpackage

// File: rtl/noc_intr_rr_pick.sv
// -----------------------------------------------------------------------------
// noc_intr_rr_pick
// Combinational round-robin picker: selects the first set bit of req at or
// after ptr, wrapping past NUM_REQ-1 back to 0.
// Ports:
//   req        in  NUM_REQ  request vector
//   ptr        in  IDX_W    search start position (must be < NUM_REQ)
//   grant      out NUM_REQ  one-hot grant (all zero when req is zero)
//   grant_idx  out IDX_W    binary index of the granted bit
// -----------------------------------------------------------------------------
module noc_intr_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  localparam int SW = IDX_W + 1;

  logic          found;
  logic [SW-1:0] pos;

  // NOTE: every variable assigned in a combinational block gets a default
  // first, so no path leaves it holding a value and a latch is never inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    pos       = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      // One extra bit absorbs ptr+off; one subtraction wraps since both < NUM_REQ.
      pos = {1'b0, ptr} + SW'(off);
      if (pos >= SW'(NUM_REQ)) pos = pos - SW'(NUM_REQ);
      if (!found && req[pos[IDX_W-1:0]]) begin
        found                   = 1'b1;
        grant[pos[IDX_W-1:0]]   = 1'b1;
        grant_idx               = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/noc_intr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_intr_arbiter
// Round-robin arbiter that turns per-requester interrupt requests into
// two-flit NoC packets (header + one body flit). A packet, once granted,
// is sent atomically; the next search starts one past the last grant.
// Optional feature: define NOC_INTR_ARB_DROP_INVALID_EN to drop requests
// whose tile id is >= NUM_TILES (accepted, no flits, err_drop pulses).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   req_val        in  NUM_REQ     per-requester pending
//   req_rdy        out NUM_REQ     one-hot acceptance pulse
//   req_tileid     in  NUM_REQ*32  destination tile id per requester
//   req_payload    in  NUM_REQ*64  body flit per requester
//   noc_out_val    out 1           flit valid
//   noc_out_rdy    in  1           downstream ready
//   noc_out_data   out 64          flit
//   err_drop       out 1           invalid-tile drop pulse (feature only)
// -----------------------------------------------------------------------------
module noc_intr_arbiter
  import noc_intr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int X_TILES   = 3,
  parameter int NUM_TILES = 9
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_val,
  output logic [NUM_REQ-1:0]        req_rdy,
  input  logic [NUM_REQ*32-1:0]     req_tileid,
  input  logic [NUM_REQ*64-1:0]     req_payload,
  output logic                      noc_out_val,
  input  logic                      noc_out_rdy,
`ifdef NOC_INTR_ARB_DROP_INVALID_EN
  output logic                      err_drop,
`endif
  output logic [NOC_DATA_WIDTH-1:0] noc_out_data
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e                state_q, state_d;
  logic [IDX_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]          grant_idx_q, grant_idx_d;
  logic [31:0]               tileid_q, tileid_d;
  logic [NOC_DATA_WIDTH-1:0] payload_q, payload_d;

  logic [NUM_REQ-1:0]        pick_grant;
  logic [IDX_W-1:0]          pick_idx;
  logic [31:0]               sel_tileid;
  logic [NOC_DATA_WIDTH-1:0] sel_payload;
  logic [NOC_DATA_WIDTH-1:0] hdr_flit;

`ifdef NOC_INTR_ARB_DROP_INVALID_EN
  logic err_drop_q, err_drop_d;
  assign err_drop = err_drop_q;
`endif

  noc_intr_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req_val),
    .ptr       (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  assign sel_tileid  = req_tileid[pick_idx*32 +: 32];
  assign sel_payload = req_payload[pick_idx*64 +: 64];

  // Destination coordinates derived from the latched id, truncated to field width.
  assign hdr_flit = make_intr_hdr(NOC_X_WIDTH'(tileid_q % 32'(X_TILES)),
                                  NOC_Y_WIDTH'(tileid_q / 32'(X_TILES)));

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] p);
    return (p == IDX_W'(NUM_REQ - 1)) ? '0 : p + IDX_W'(1);
  endfunction

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_idx_d  = grant_idx_q;
    tileid_d     = tileid_q;
    payload_d    = payload_q;
    req_rdy      = '0;
    noc_out_val  = 1'b0;
    noc_out_data = '0;
`ifdef NOC_INTR_ARB_DROP_INVALID_EN
    err_drop_d   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (|req_val) begin
          req_rdy     = pick_grant;
          grant_idx_d = pick_idx;
          tileid_d    = sel_tileid;
          payload_d   = sel_payload;
`ifdef NOC_INTR_ARB_DROP_INVALID_EN
          if (sel_tileid >= 32'(NUM_TILES)) begin
            err_drop_d = 1'b1;
            rr_ptr_d   = next_ptr(pick_idx);
          end else begin
            state_d = ST_HDR;
          end
`else
          state_d = ST_HDR;
`endif
        end
      end
      ST_HDR: begin
        noc_out_val  = 1'b1;
        noc_out_data = hdr_flit;
        if (noc_out_rdy) state_d = ST_BODY;
      end
      ST_BODY: begin
        noc_out_val  = 1'b1;
        noc_out_data = payload_q;
        if (noc_out_rdy) begin
          rr_ptr_d = next_ptr(grant_idx_q);
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // No acceptance while reset is held, even though the state already reads IDLE.
    if (rst) req_rdy = '0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      tileid_q    <= '0;
      payload_q   <= '0;
`ifdef NOC_INTR_ARB_DROP_INVALID_EN
      err_drop_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      tileid_q    <= tileid_d;
      payload_q   <= payload_d;
`ifdef NOC_INTR_ARB_DROP_INVALID_EN
      err_drop_q  <= err_drop_d;
`endif
    end
  end

endmodule
